fir_sym_mc: RTL
===============

// Module: fir_sym_mc
// PURPOSE
//  Time-multiplexed symmetric FIR for N_CH independent channels; single clock, no derived slow clock.
//  Per-channel delay line, pre-adder folding tap pairs, one multiplier/accumulator, runtime-loadable coefficients.
//  Sits between the sample source (valid/ready) and the downstream consumer (valid pulse, no backpressure).
// PARAMETERS
//  WIDTH_DATA   8   signed input sample width
//  WIDTH_COEF   8   signed coefficient width
//  N_TAPS       16  filter length; even, >=4; N_TAPS/2 unique coefficients
//  LOG2_N_TAPS  4   clog2(N_TAPS)
//  N_CH         2   channel count, >=1
//  LOG2_N_CH    1   max(1, clog2(N_CH))
//  WIDTH_OUT    16  signed output width
//  OUT_SHIFT    0   arithmetic right shift applied to the accumulator before output
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous, active-low reset
//  in_valid   in   1              sample offered
//  in_ready   out  1              block can accept a sample
//  in_ch      in   LOG2_N_CH      channel of offered sample
//  din        in   WIDTH_DATA     signed sample
//  coef_we    in   1              coefficient write strobe
//  coef_addr  in   LOG2_N_TAPS-1  coefficient index k, 0..N_TAPS/2-1
//  coef_data  in   WIDTH_COEF     signed coefficient h[k]
//  out_valid  out  1              one-cycle pulse, dout/out_ch valid
//  out_ch     out  LOG2_N_CH      channel of result
//  dout       out  WIDTH_OUT      signed filtered result
//  busy       out  1              state != IDLE
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE, all delay lines and coefficients 0, accumulator 0.
//    out_valid=0, dout=0, out_ch=0. Reset mid-computation aborts; no out_valid is produced.
//  - FSM: IDLE -> MAC (N_TAPS/2 cycles, k=0..N_TAPS/2-1) -> DONE (1 cycle) -> IDLE.
//  - in_ready = (state==IDLE) & ~coef_we. Accept edge E0: in_valid & in_ready.
//    Shift din into the in_ch delay line (x[n] at index 0), latch channel, clear acc, go to MAC.
//  - in_ch >= N_CH: sample accepted and discarded; no state change, no out_valid.
//  - MAC, cycle k: acc += h[k] * (x[k] + x[N_TAPS-1-k]).
//    Pre-add is WIDTH_DATA+1 bits; acc is WIDTH_DATA+WIDTH_COEF+LOG2_N_TAPS bits, full precision, never wraps.
//  - At edge E(N_TAPS/2), the final term is folded in, dout registered, out_valid=1, state DONE.
//    dout = (acc >>> OUT_SHIFT) reduced to WIDTH_OUT (see CONFIGURATION).
//  - Edge E(N_TAPS/2+1): out_valid=0, state IDLE; dout holds its value.
//    Next accept no earlier than E(N_TAPS/2+2); throughput 1 sample per N_TAPS/2+2 cycles.
//  - Latency: out_valid is observed high in the cycle after edge E(N_TAPS/2).
//  - Coefficients: write h[coef_addr]=coef_data only in IDLE. Writes while busy are ignored.
//    coef_we and in_valid in the same IDLE cycle: the write wins and the sample waits.
//  - Other channels' delay lines are never touched by a computation.
// CONFIGURATION
//  FIR_SAT_EN defined: dout clamps to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
//  FIR_SAT_EN undefined: dout = low WIDTH_OUT bits (two's-complement wrap).
// STRUCTURE
//  fir_pkg.vh (shared include): ACC_WIDTH and PREADD_WIDTH localparams; FSM state encodings IDLE/MAC/DONE;
//    sat/trunc function.
//  Sub-module fir_delay_bank: N_CH x N_TAPS shift registers, per-channel shift enable, two read ports (k, N_TAPS-1-k).
//  Top level: FSM, tap counter, coefficient register file, pre-adder, MAC, output stage.
// TESTING
//  1 Impulse: h=1..8, ch0 din=1 then 0s -> dout seq 1,2,..,8,8,7,..,1, then 0; out_ch=0.
//  2 Step: all h=1, ch0 din=1 held -> dout 1,2,..,16, then 16 steady.
//  3 Isolation: alternate ch0 impulse / ch1 zeros -> ch1 dout all 0; ch0 matches test 1.
//  4 Saturation: WIDTH_OUT=8, all h=127, din=127 held -> FIR_SAT_EN: dout=127; undefined: dout = low 8 bits of 127*127*2*k.
//  5 Handshake: in_valid held high -> accepts spaced exactly 10 cycles; out_valid 8 cycles after each accept;
//    coef_we in IDLE holds in_ready low.
//  6 Reset mid-MAC: rst=0 one cycle at k=3 -> no out_valid, busy=0; reload h, rerun test 1, same results.

Source files
------------

// File: rtl/fir_sym_mc_pkg.sv
// Shared types and helpers for the fir_sym_mc symmetric multichannel FIR.
// FIR_SAT_EN selects clamping (defined) or two's-complement wrap (undefined) in reduce_out.
package fir_sym_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Accumulator width: full precision across all N_TAPS/2 folded products.
    function automatic int acc_width(input int wd, input int wc, input int lt);
        return wd + wc + lt;
    endfunction

    function automatic int preadd_width(input int wd);
        return wd + 1;
    endfunction

    // Bring a wide signed value into a w-bit signed range; caller keeps the low w bits.
    function automatic logic signed [63:0] reduce_out(input logic signed [63:0] v, input int w);
`ifdef FIR_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/fir_sym_mc_if.sv
// Sample, coefficient and result signals of fir_sym_mc.
// master = sample source / coefficient loader / consumer side, slave = the filter.
interface fir_sym_mc_if #(
    parameter int WIDTH_DATA  = 8,
    parameter int WIDTH_COEF  = 8,
    parameter int LOG2_N_TAPS = 4,
    parameter int LOG2_N_CH   = 1,
    parameter int WIDTH_OUT   = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LOG2_N_CH-1:0]          in_ch;
    logic signed [WIDTH_DATA-1:0]  din;
    logic                          coef_we;
    logic [LOG2_N_TAPS-2:0]        coef_addr;
    logic signed [WIDTH_COEF-1:0]  coef_data;
    logic                          out_valid;
    logic [LOG2_N_CH-1:0]          out_ch;
    logic signed [WIDTH_OUT-1:0]   dout;
    logic                          busy;

    modport master (
        output in_valid, in_ch, din, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_ch, dout, busy
    );

    modport slave (
        input  in_valid, in_ch, din, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_ch, dout, busy
    );
endinterface

// File: rtl/fir_sym_mc_delay_bank.sv
// Per-channel sample delay lines (newest sample at index 0) with two
// combinational read ports on one selected channel for the symmetric tap pair.
module fir_sym_mc_delay_bank #(
    parameter int WIDTH_DATA  = 8,
    parameter int N_TAPS      = 16,
    parameter int LOG2_N_TAPS = 4,
    parameter int N_CH        = 2,
    parameter int LOG2_N_CH   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH-1:0]               i_shift_en,
    input  logic signed [WIDTH_DATA-1:0]  i_din,
    input  logic [LOG2_N_CH-1:0]          i_rd_ch,
    input  logic [LOG2_N_TAPS-1:0]        i_rd_a,
    input  logic [LOG2_N_TAPS-1:0]        i_rd_b,
    output logic signed [WIDTH_DATA-1:0]  o_x_a,
    output logic signed [WIDTH_DATA-1:0]  o_x_b
);
    logic signed [WIDTH_DATA-1:0] r_line [N_CH][N_TAPS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < N_TAPS; t++) begin
                    r_line[c][t] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (i_shift_en[c]) begin
                    r_line[c][0] <= i_din;
                    for (int t = 1; t < N_TAPS; t++) begin
                        r_line[c][t] <= r_line[c][t-1];
                    end
                end
            end
        end
    end

    assign o_x_a = r_line[i_rd_ch][i_rd_a];
    assign o_x_b = r_line[i_rd_ch][i_rd_b];
endmodule

// File: rtl/fir_sym_mc.sv
// Time-multiplexed symmetric FIR: one pre-adder and one MAC shared by all channels.
// Build option FIR_SAT_EN: saturate dout instead of wrapping it.
module fir_sym_mc
    import fir_sym_mc_pkg::*;
#(
    parameter int WIDTH_DATA  = 8,
    parameter int WIDTH_COEF  = 8,
    parameter int N_TAPS      = 16,
    parameter int LOG2_N_TAPS = 4,
    parameter int N_CH        = 2,
    parameter int LOG2_N_CH   = 1,
    parameter int WIDTH_OUT   = 16,
    parameter int OUT_SHIFT   = 0
) (
    input logic         clk,
    input logic         rst,
    fir_sym_mc_if.slave bus
);
    localparam int ACC_WIDTH    = acc_width(WIDTH_DATA, WIDTH_COEF, LOG2_N_TAPS);
    localparam int PREADD_WIDTH = preadd_width(WIDTH_DATA);
    localparam int PROD_WIDTH   = PREADD_WIDTH + WIDTH_COEF;
    localparam int K_W          = LOG2_N_TAPS - 1;
    localparam int N_COEF       = N_TAPS / 2;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_COEF - 1);

    state_t                          r_state;
    state_t                          w_state_next;
    logic [K_W-1:0]                  r_k;
    logic [LOG2_N_CH-1:0]            r_ch;
    logic [LOG2_N_CH-1:0]            r_out_ch;
    logic signed [ACC_WIDTH-1:0]     r_acc;
    logic signed [ACC_WIDTH-1:0]     w_acc_sum;
    logic signed [WIDTH_COEF-1:0]    r_coef [N_COEF];
    logic signed [WIDTH_OUT-1:0]     r_dout;
    logic signed [WIDTH_OUT-1:0]     w_dout_next;
    logic                            r_out_valid;
    logic                            w_in_ready;
    logic                            w_ch_ok;
    logic                            w_start;
    logic                            w_coef_wr;
    logic                            w_last;
    logic [N_CH-1:0]                 w_shift_en;
    logic [LOG2_N_TAPS-1:0]          w_rd_a;
    logic [LOG2_N_TAPS-1:0]          w_rd_b;
    logic signed [WIDTH_DATA-1:0]    w_x_a;
    logic signed [WIDTH_DATA-1:0]    w_x_b;
    logic signed [PREADD_WIDTH-1:0]  w_preadd;
    logic signed [PROD_WIDTH-1:0]    w_prod;

    // Out-of-range channel numbers are accepted but dropped without starting a pass.
    generate
        if (N_CH == (1 << LOG2_N_CH)) begin : g_ch_full
            assign w_ch_ok = 1'b1;
        end else begin : g_ch_part
            assign w_ch_ok = (int'(bus.in_ch) < N_CH);
        end
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_shift
            assign w_shift_en[gi] = w_start & (bus.in_ch == LOG2_N_CH'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_start      = 1'b0;
        w_coef_wr    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A coefficient write takes the cycle; the sample waits.
                w_in_ready = ~bus.coef_we;
                w_coef_wr  = bus.coef_we;
                w_start    = bus.in_valid & ~bus.coef_we & w_ch_ok;
                if (w_start) w_state_next = ST_MAC;
            end
            ST_MAC: begin
                w_last = (r_k == K_LAST);
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    fir_sym_mc_delay_bank #(
        .WIDTH_DATA (WIDTH_DATA),
        .N_TAPS     (N_TAPS),
        .LOG2_N_TAPS(LOG2_N_TAPS),
        .N_CH       (N_CH),
        .LOG2_N_CH  (LOG2_N_CH)
    ) u_delay_bank (
        .clk       (clk),
        .rst       (rst),
        .i_shift_en(w_shift_en),
        .i_din     (bus.din),
        .i_rd_ch   (r_ch),
        .i_rd_a    (w_rd_a),
        .i_rd_b    (w_rd_b),
        .o_x_a     (w_x_a),
        .o_x_b     (w_x_b)
    );

    // Tap pair k and N_TAPS-1-k share coefficient h[k].
    assign w_rd_a      = {1'b0, r_k};
    assign w_rd_b      = LOG2_N_TAPS'(N_TAPS - 1) - w_rd_a;
    assign w_preadd    = PREADD_WIDTH'(w_x_a) + PREADD_WIDTH'(w_x_b);
    assign w_prod      = PROD_WIDTH'(w_preadd) * PROD_WIDTH'(r_coef[r_k]);
    assign w_acc_sum   = r_acc + ACC_WIDTH'(w_prod);
    assign w_dout_next = WIDTH_OUT'(reduce_out(64'(w_acc_sum) >>> OUT_SHIFT, WIDTH_OUT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_k         <= '0;
            r_ch        <= '0;
            r_acc       <= '0;
            r_dout      <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < N_COEF; i++) r_coef[i] <= '0;
        end else begin
            r_out_valid <= w_last;
            if (w_coef_wr) r_coef[bus.coef_addr] <= bus.coef_data;
            if (w_start) begin
                r_ch  <= bus.in_ch;
                r_acc <= '0;
                r_k   <= '0;
            end else if (r_state == ST_MAC) begin
                r_acc <= w_acc_sum;
                r_k   <= r_k + K_W'(1);
            end
            if (w_last) begin
                r_dout   <= w_dout_next;
                r_out_ch <= r_ch;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.dout      = r_dout;
    assign bus.busy      = (r_state != ST_IDLE);
endmodule
